// File: rtl/ep_arith_pkg.sv
// Shared definitions for the arithmetic endpoint bank: operation modes,
// channel FSM state encoding and the multiply-counter width helper.
package ep_arith_pkg;

    // Operation selectors carried on the per-channel mode WireIn bits
    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_MUL = 2'b10;
    localparam logic [1:0] MODE_ACC = 2'b11;

    // Channel FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Bits needed to hold a multiply counter loaded with the operand width
    function automatic int cnt_width(input int width);
        return $clog2(width + 32'sd1);
    endfunction

endpackage

// File: rtl/ep_arith_channel.sv
// One arithmetic channel: IDLE/EXEC/DONE control, operand latches,
// shift-add multiplier, running accumulator and sticky overflow flag.
module ep_arith_channel
    import ep_arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 ti_clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic [1:0]           mode,
    input  logic                 start,
    input  logic                 clear,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    state_e            state_r;
    state_e            state_next_s;
    logic              accept_s;
    logic              finish_s;

    logic [1:0]        mode_r;
    logic [RW-1:0]     mcand_r;      // zero-extended A; shifts left during a multiply
    logic [WIDTH-1:0]  mplier_r;     // B; shifts right during a multiply
    logic [CW-1:0]     cnt_r;
    logic [RW-1:0]     prod_r;
    logic [RW-1:0]     result_r;
    logic              ovf_r;
    logic              busy_r;
    logic              done_r;

    logic [RW-1:0]     b_ext_s;
    logic [RW-1:0]     prod_step_s;
    logic [RW:0]       acc_sum_s;
    logic              acc_carry_s;
    logic [RW-1:0]     exec_result_s;

    // Next-state decode; clear wins over start, a start during EXEC is dropped
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        finish_s     = 1'b0;
        if (clear) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_next_s = ST_EXEC;
                        accept_s     = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if ((mode_r != MODE_MUL) || (cnt_r == CNT_ONE)) begin
                        state_next_s = ST_DONE;
                        finish_s     = 1'b1;
                    end else begin
                        state_next_s = ST_EXEC;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Arithmetic for the latched operation; everything wraps at 2*WIDTH bits
    always_comb begin
        b_ext_s       = {{WIDTH{1'b0}}, mplier_r};
        acc_sum_s     = {1'b0, result_r} + {1'b0, mcand_r};
        acc_carry_s   = acc_sum_s[RW];
        prod_step_s   = prod_r;
        exec_result_s = result_r;
        if (mplier_r[0]) begin
            prod_step_s = prod_r + mcand_r;
        end else begin
            prod_step_s = prod_r;
        end
        case (mode_r)
            MODE_ADD: exec_result_s = mcand_r + b_ext_s;
            MODE_SUB: exec_result_s = mcand_r - b_ext_s;
            MODE_MUL: exec_result_s = prod_step_s;
            MODE_ACC: exec_result_s = acc_sum_s[RW-1:0];
            default:  exec_result_s = result_r;
        endcase
    end

    // FSM state register
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Busy/done status registered from the next state so outputs stay flop-driven
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_EXEC);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    // Operand latches, shift-add multiplier, result and sticky overflow
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r   <= MODE_ADD;
            mcand_r  <= {RW{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            prod_r   <= {RW{1'b0}};
            result_r <= {RW{1'b0}};
            ovf_r    <= 1'b0;
        end else if (clear) begin
            mcand_r  <= {RW{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            prod_r   <= {RW{1'b0}};
            result_r <= {RW{1'b0}};
            ovf_r    <= 1'b0;
        end else if (accept_s) begin
            mode_r   <= mode;
            mcand_r  <= {{WIDTH{1'b0}}, op_a};
            mplier_r <= op_b;
            cnt_r    <= CNT_LOAD;
            prod_r   <= {RW{1'b0}};
        end else if (state_r == ST_EXEC) begin
            if (mode_r == MODE_MUL) begin
                prod_r   <= prod_step_s;
                mcand_r  <= mcand_r << 1;
                mplier_r <= mplier_r >> 1;
                cnt_r    <= cnt_r - CNT_ONE;
                if (finish_s) begin
                    result_r <= exec_result_s;
                end
            end else begin
                result_r <= exec_result_s;
                cnt_r    <= {CW{1'b0}};
                if ((mode_r == MODE_ACC) && acc_carry_s) begin
                    ovf_r <= 1'b1;
                end
            end
        end
    end

    assign result = result_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign ovf    = ovf_r;

endmodule

// File: rtl/ep_arith_bank.sv
// Multi-channel arithmetic endpoint bank: NCH independent channels with
// their operands, modes and results packed onto flat endpoint buses.
module ep_arith_bank
    import ep_arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 2
) (
    input  logic                    ti_clk,
    input  logic                    rst_n,
    input  logic [NCH*WIDTH-1:0]    op_a,
    input  logic [NCH*WIDTH-1:0]    op_b,
    input  logic [NCH*2-1:0]        mode,
    input  logic [NCH-1:0]          start,
    input  logic [NCH-1:0]          clear,
    output logic [NCH*2*WIDTH-1:0]  result,
    output logic [NCH-1:0]          busy,
    output logic [NCH-1:0]          done,
    output logic [NCH-1:0]          ovf
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ep_arith_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .ti_clk (ti_clk),
            .rst_n  (rst_n),
            .op_a   (op_a[i*WIDTH +: WIDTH]),
            .op_b   (op_b[i*WIDTH +: WIDTH]),
            .mode   (mode[i*2 +: 2]),
            .start  (start[i]),
            .clear  (clear[i]),
            .result (result[i*2*WIDTH +: 2*WIDTH]),
            .busy   (busy[i]),
            .done   (done[i]),
            .ovf    (ovf[i])
        );
    end

endmodule

// File: tb/tb_ep_arith_bank.sv
// Self-checking bench for ep_arith_bank: directed table, multi-cycle corner
// sequences and randomized operations against a behavioural model.
module tb_ep_arith_bank;
    import ep_arith_pkg::*;

    localparam int WIDTH = 16;
    localparam int NCH   = 2;
    localparam int RW    = 2 * WIDTH;

    logic                  ti_clk = 1'b0;
    logic                  rst_n;
    logic [NCH*WIDTH-1:0]  op_a;
    logic [NCH*WIDTH-1:0]  op_b;
    logic [NCH*2-1:0]      mode;
    logic [NCH-1:0]        start;
    logic [NCH-1:0]        clear;
    logic [NCH*RW-1:0]     result;
    logic [NCH-1:0]        busy;
    logic [NCH-1:0]        done;
    logic [NCH-1:0]        ovf;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  m;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] res;
        int          lat;
        int          bsy;
        logic        ov;
    } vec_t;

    vec_t tbl [7];

    always #5 ti_clk = ~ti_clk;

    ep_arith_bank #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .ti_clk (ti_clk),
        .rst_n  (rst_n),
        .op_a   (op_a),
        .op_b   (op_b),
        .mode   (mode),
        .start  (start),
        .clear  (clear),
        .result (result),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf)
    );

    task automatic tick();
        @(posedge ti_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Pulse start on one channel and wait (bounded) for its done pulse
    task automatic run_op(input int ch, input logic [1:0] m, input logic [15:0] a,
                          input logic [15:0] b, output int lat, output int bcnt,
                          output logic [31:0] res);
        op_a[ch*WIDTH +: WIDTH] = a;
        op_b[ch*WIDTH +: WIDTH] = b;
        mode[ch*2 +: 2]         = m;
        start[ch]               = 1'b1;
        tick();
        start[ch] = 1'b0;
        lat  = 1;
        bcnt = busy[ch] ? 1 : 0;
        while (!done[ch] && lat < 40) begin
            tick();
            lat++;
            if (busy[ch]) bcnt++;
        end
        res = result[ch*RW +: RW];
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          bcnt;
        int          dcnt;
        int          d0;
        int          d1;
        logic [31:0] res;
        logic [31:0] m_res [NCH];
        logic        m_ovf [NCH];
        logic [63:0] sum_w;
        int          ch;
        logic [1:0]  m;
        logic [15:0] a;
        logic [15:0] b;

        tbl[0] = '{MODE_ADD, 16'hFFFF, 16'h0001, 32'h0001_0000, 2,  1,  1'b0};
        tbl[1] = '{MODE_SUB, 16'h0003, 16'h0005, 32'hFFFF_FFFE, 2,  1,  1'b0};
        tbl[2] = '{MODE_MUL, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 17, 16, 1'b0};
        tbl[3] = '{MODE_ACC, 16'hFFFF, 16'h0000, 32'hFFFF_0000, 2,  1,  1'b0};
        tbl[4] = '{MODE_ACC, 16'hFFFF, 16'h0000, 32'hFFFF_FFFF, 2,  1,  1'b0};
        tbl[5] = '{MODE_ACC, 16'hFFFF, 16'h0000, 32'h0000_FFFE, 2,  1,  1'b1};
        tbl[6] = '{MODE_ADD, 16'h1234, 16'h0010, 32'h0000_1244, 2,  1,  1'b1};

        rst_n = 1'b0;
        op_a  = '0;
        op_b  = '0;
        mode  = '0;
        start = '0;
        clear = '0;
        repeat (3) tick();
        check("reset_result", result, 64'h0);
        check("reset_busy", busy, 64'h0);
        check("reset_done", done, 64'h0);
        check("reset_ovf", ovf, 64'h0);
        rst_n = 1'b1;
        tick();

        // Directed table on channel 0
        for (int i = 0; i < 7; i++) begin
            run_op(0, tbl[i].m, tbl[i].a, tbl[i].b, lat, bcnt, res);
            check($sformatf("tbl%0d_result", i), res, tbl[i].res);
            check($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("tbl%0d_busy_cycles", i), bcnt, tbl[i].bsy);
            check($sformatf("tbl%0d_ovf", i), ovf[0], tbl[i].ov);
        end

        // Second start during the busy cycle is ignored
        op_a[15:0] = 16'h0003; op_b[15:0] = 16'h0005; mode[1:0] = MODE_SUB;
        start[0] = 1'b1;
        tick();
        op_a[15:0] = 16'h0007; op_b[15:0] = 16'h0007; mode[1:0] = MODE_ADD;
        tick();
        start[0] = 1'b0;
        dcnt = done[0] ? 1 : 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (done[0]) dcnt++;
        end
        check("sub_ignore_result", result[31:0], 32'hFFFF_FFFE);
        check("sub_single_done", dcnt, 1);

        // Operand change mid-multiply has no effect
        op_a[15:0] = 16'hFFFF; op_b[15:0] = 16'hFFFF; mode[1:0] = MODE_MUL;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        lat = 1;
        while (!done[0] && lat < 40) begin
            tick();
            lat++;
            if (lat == 3) begin
                op_a[15:0] = 16'h0003;
                op_b[15:0] = 16'h0003;
            end
        end
        check("mul_opchg_result", result[31:0], 32'hFFFE_0001);
        check("mul_opchg_latency", lat, 17);

        // Clear at cycle 5 of a multiply; ovf is still set from the table
        check("pre_clear_ovf", ovf[0], 1'b1);
        op_a[15:0] = 16'h0123; op_b[15:0] = 16'h0456; mode[1:0] = MODE_MUL;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (4) tick();
        clear[0] = 1'b1;
        tick();
        clear[0] = 1'b0;
        check("clear_busy", busy[0], 1'b0);
        check("clear_result", result[31:0], 32'h0);
        check("clear_ovf", ovf[0], 1'b0);
        dcnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (done[0]) dcnt++;
            tick();
        end
        check("clear_no_done", dcnt, 0);

        // Start and clear together: no operation
        op_a[15:0] = 16'h0001; op_b[15:0] = 16'h0001; mode[1:0] = MODE_ADD;
        start[0] = 1'b1;
        clear[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        clear[0] = 1'b0;
        check("startclr_busy", busy[0], 1'b0);
        dcnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (done[0]) dcnt++;
            tick();
        end
        check("startclr_no_done", dcnt, 0);
        check("startclr_result", result[31:0], 32'h0);

        // Channel independence: ch0 multiply and ch1 add started together
        op_a = {16'h8000, 16'h00FF};
        op_b = {16'h8000, 16'h0101};
        mode = {MODE_ADD, MODE_MUL};
        start = 2'b11;
        tick();
        start = 2'b00;
        d0 = -1;
        d1 = -1;
        for (int c = 1; c <= 25; c++) begin
            if (done[0] && d0 < 0) d0 = c;
            if (done[1] && d1 < 0) d1 = c;
            tick();
        end
        check("indep_ch1_done_at", d1, 2);
        check("indep_ch0_done_at", d0, 17);
        check("indep_ch0_result", result[31:0], 32'h0000_FFFF);
        check("indep_ch1_result", result[63:32], 32'h0001_0000);

        // Back-to-back: start during the done cycle is accepted
        run_op(1, MODE_ADD, 16'h0001, 16'h0002, lat, bcnt, res);
        check("b2b_first_result", res, 32'h0000_0003);
        run_op(1, MODE_ADD, 16'h0005, 16'h0006, lat, bcnt, res);
        check("b2b_second_latency", lat, 2);
        check("b2b_second_result", res, 32'h0000_000B);

        // Asynchronous reset in the middle of a multiply
        op_a[15:0] = 16'h00AB; op_b[15:0] = 16'h00CD; mode[1:0] = MODE_MUL;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_result", result, 64'h0);
        check("async_rst_busy", busy, 64'h0);
        check("async_rst_done", done, 64'h0);
        check("async_rst_ovf", ovf, 64'h0);
        tick();
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done[0] || busy[0]) dcnt++;
        end
        check("async_rst_aborted", dcnt, 0);

        // Randomized operations against a behavioural model
        for (int c = 0; c < NCH; c++) begin
            m_res[c] = 32'h0;
            m_ovf[c] = 1'b0;
        end
        for (int i = 0; i < 60; i++) begin
            ch = int'($urandom_range(1, 0));
            if ($urandom_range(9, 0) == 0) begin
                clear[ch] = 1'b1;
                tick();
                clear[ch] = 1'b0;
                m_res[ch] = 32'h0;
                m_ovf[ch] = 1'b0;
                check($sformatf("rnd%0d_clear_result", i), result[ch*RW +: RW], m_res[ch]);
            end
            m = 2'($urandom_range(3, 0));
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(3, 0) == 0) a = 16'hFFFF;
            case (m)
                MODE_ADD: m_res[ch] = 32'(a) + 32'(b);
                MODE_SUB: m_res[ch] = 32'(a) - 32'(b);
                MODE_MUL: m_res[ch] = 32'(a) * 32'(b);
                default: begin
                    sum_w = 64'(m_res[ch]) + 64'(a);
                    if (sum_w > 64'h0000_0000_FFFF_FFFF) m_ovf[ch] = 1'b1;
                    m_res[ch] = sum_w[31:0];
                end
            endcase
            run_op(ch, m, a, b, lat, bcnt, res);
            check($sformatf("rnd%0d_ch%0d_m%0d_result", i, ch, m), res, m_res[ch]);
            check($sformatf("rnd%0d_ch%0d_ovf", i, ch), ovf[ch], m_ovf[ch]);
            check($sformatf("rnd%0d_ch%0d_latency", i, ch), lat, (m == MODE_MUL) ? 17 : 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
